round_scheduler: RTL and testbench

Sequencer for one `round_block` instance in the sparse-by-normal polynomial multiplier. The multiply runs one round per sparse-support entry, for a fixed `WEIGHT` entries. In each round the block:
- streams the normal polynomial from word memory into `round_block`;
- drives its mode and offset controls, and clears it between rounds;
- pads every round to a constant length with dummy `only_add` issues, so runtime is independent of the secret sparse positions.

---
 rtl/polymult_pkg.sv | 50 +++++
 rtl/round_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_round_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/polymult_pkg.sv
// Shared definitions for the sparse-by-normal polynomial multiplier:
// sparse-entry layout, queue-derived offset limit and scheduler states.
package polymult_pkg;

    localparam int SP_ENTRY_W    = 14;
    localparam int SP_SHIFT_LSB  = 0;
    localparam int SP_SHIFT_W    = 5;
    localparam int SP_DIFF_LSB   = 5;
    localparam int SP_DIFF_W     = 6;
    localparam int SP_LO_LAT_BIT = 11;
    localparam int SP_HI_LAT_BIT = 12;
    localparam int SP_DUMMY_BIT  = 13;

    typedef struct packed {
        logic                  dummy;
        logic                  hi_lat;
        logic                  lo_lat;
        logic [SP_DIFF_W-1:0]  diff;
        logic [SP_SHIFT_W-1:0] shift;
    } sp_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_CLEAR,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_FINISH
    } sched_state_e;

    // The round_block queue keeps three slots in reserve, so the largest
    // usable normal/sparse word offset is three less than its depth.
    function automatic int calc_max_diff(input int queue_size);
        return queue_size - 3;
    endfunction

    function automatic sp_entry_t unpack_entry(input logic [SP_ENTRY_W-1:0] raw);
        sp_entry_t e;
        e.dummy  = raw[SP_DUMMY_BIT];
        e.hi_lat = raw[SP_HI_LAT_BIT];
        e.lo_lat = raw[SP_LO_LAT_BIT];
        e.diff   = raw[SP_DIFF_LSB +: SP_DIFF_W];
        e.shift  = raw[SP_SHIFT_LSB +: SP_SHIFT_W];
        return e;
    endfunction

endpackage

// File: rtl/round_scheduler.sv
// Round sequencer for one round_block: streams the normal polynomial once
// per sparse entry and pads every round to the same number of issues so the
// run time does not reveal the sparse positions.
//
// state  | meaning
// IDLE   | waiting for start, all outputs at rest
// LOAD   | sparse entry address presented
// CHECK  | sparse entry captured, offset range checked
// CLEAR  | round_block held in clear for two cycles
// FETCH  | normal word address presented
// ISSUE  | word handed to round_block (valid pulse)
// WAIT   | word and mode held until round_block reports completion
// NEXT   | round closed, advance to the next entry or finish
// FINISH | done pulse
module round_scheduler
    import polymult_pkg::*;
#(
    parameter int WORD_WIDTH        = 32,
    parameter int NORMAL_WORD_COUNT = 553,
    parameter int QUEUE_SIZE        = 19,
    parameter int WEIGHT            = 66,
    parameter int ADDR_WIDTH        = 10,
    localparam int SP_AW            = (WEIGHT > 1) ? $clog2(WEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [SP_AW-1:0]      sp_addr,
    input  logic [SP_ENTRY_W-1:0] sp_rdata,
    output logic [ADDR_WIDTH-1:0] nw_addr,
    input  logic [WORD_WIDTH-1:0] nw_rdata,
    output logic                  rb_rst_n,
    output logic [WORD_WIDTH-1:0] rb_word,
    output logic                  rb_word_valid,
    output logic                  rb_only_add,
    output logic [SP_DIFF_W-1:0]  rb_sparse_diff,
    output logic                  rb_high_latency,
    output logic                  rb_low_latency,
    input  logic                  rb_processing_done,
    output logic                  acc_round_start,
    output logic                  acc_round_last,
    output logic [SP_SHIFT_W-1:0] acc_shift,
    output logic                  acc_dummy
);

    localparam int                   MAX_DIFF    = calc_max_diff(QUEUE_SIZE);
    localparam logic [9:0]           NWC_10      = 10'(NORMAL_WORD_COUNT);
    localparam logic [9:0]           ISSUE_LAST  = 10'(NORMAL_WORD_COUNT + MAX_DIFF);
    localparam logic [SP_DIFF_W-1:0] MAX_DIFF_W  = SP_DIFF_W'(MAX_DIFF);
    localparam logic [SP_AW-1:0]     ROUND_LAST  = SP_AW'(WEIGHT - 1);

    sched_state_e          state_q, state_d;
    logic [SP_AW-1:0]      round_q, round_d;
    logic [9:0]            issue_q, issue_d;
    logic                  clr_q, clr_d;
    sp_entry_t             entry_q, entry_d;
    logic                  error_q, error_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;

    sp_entry_t             entry_in;
    logic                  issue_in_range;
    logic [WORD_WIDTH-1:0] word_live;
    logic [10:0]           real_last;
    logic                  in_round;
    logic                  in_issue;

    assign entry_in       = unpack_entry(sp_rdata);
    assign issue_in_range = (issue_q < NWC_10);
    // Words past the end of the normal polynomial are padding and carry zero.
    assign word_live      = issue_in_range ? nw_rdata : '0;
    assign real_last      = 11'(NORMAL_WORD_COUNT) + {5'b0, entry_q.diff};
    assign in_round       = state_q inside {ST_CLEAR, ST_FETCH, ST_ISSUE, ST_WAIT, ST_NEXT};
    assign in_issue       = state_q inside {ST_ISSUE, ST_WAIT};

    // Next-state and counter update logic.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        issue_d = issue_q;
        clr_d   = clr_q;
        entry_d = entry_q;
        error_d = error_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    round_d = '0;
                    error_d = 1'b0;
                end
            end
            ST_LOAD: state_d = ST_CHECK;
            ST_CHECK: begin
                if (entry_in.diff > MAX_DIFF_W) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    entry_d = entry_in;
                    clr_d   = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                issue_d = '0;
                clr_d   = 1'b1;
                if (clr_q) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_ISSUE;
            ST_ISSUE: begin
                word_d  = word_live;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rb_processing_done) begin
                    if (issue_q == ISSUE_LAST) begin
                        state_d = ST_NEXT;
                    end else begin
                        issue_d = issue_q + 10'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_NEXT: begin
                if (round_q == ROUND_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    round_d = round_q + SP_AW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            issue_q <= '0;
            clr_q   <= 1'b0;
            entry_q <= '0;
            error_q <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            issue_q <= issue_d;
            clr_q   <= clr_d;
            entry_q <= entry_d;
            error_q <= error_d;
            word_q  <= word_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_FINISH);
    assign error           = error_q;
    assign sp_addr         = (state_q == ST_LOAD) ? round_q : '0;
    assign nw_addr         = ((state_q == ST_FETCH) && issue_in_range) ? ADDR_WIDTH'(issue_q) : '0;
    // The clear must also reach round_block while the scheduler itself is in reset.
    assign rb_rst_n        = ~rst & ~(state_q == ST_CLEAR);
    assign rb_word_valid   = (state_q == ST_ISSUE);
    assign rb_word         = (state_q == ST_ISSUE) ? word_live :
                             (state_q == ST_WAIT)  ? word_q    : '0;
    // Issue 0 only primes the queue; issues beyond the last real offset are padding.
    assign rb_only_add     = in_issue && ((issue_q == '0) || ({1'b0, issue_q} > real_last));
    assign rb_sparse_diff  = in_round ? entry_q.diff   : '0;
    assign rb_high_latency = in_round & entry_q.hi_lat;
    assign rb_low_latency  = in_round & entry_q.lo_lat;
    assign acc_shift       = in_round ? entry_q.shift  : '0;
    assign acc_dummy       = in_round & entry_q.dummy;
    assign acc_round_start = (state_q == ST_CLEAR) & ~clr_q;
    assign acc_round_last  = (state_q == ST_NEXT);

endmodule

// File: tb/tb_round_scheduler.sv
// Bench for round_scheduler with a three-entry multiply, a fixed-latency
// round_block stand-in and a behavioural model of the expected word stream.
module tb_round_scheduler;
    import polymult_pkg::*;

    localparam int WW     = 32;
    localparam int NWC    = 553;
    localparam int QS     = 19;
    localparam int WT     = 3;
    localparam int AW     = 10;
    localparam int MAXD   = QS - 3;
    localparam int ISSUES = NWC + MAXD + 1;
    // LOAD + CHECK + 2 CLEAR, 570 issues of 5 cycles, NEXT; plus FINISH.
    localparam int EXP_CYC = WT * (4 + ISSUES * 5 + 1) + 1;
    localparam int STUB_LAT = 2;

    logic                  clk = 1'b0;
    logic                  rst, start;
    logic                  busy, done, error;
    logic [1:0]            sp_addr;
    logic [SP_ENTRY_W-1:0] sp_rdata;
    logic [AW-1:0]         nw_addr;
    logic [WW-1:0]         nw_rdata;
    logic                  rb_rst_n, rb_word_valid, rb_only_add;
    logic [WW-1:0]         rb_word;
    logic [5:0]            rb_sparse_diff;
    logic                  rb_high_latency, rb_low_latency;
    logic                  rb_processing_done;
    logic                  acc_round_start, acc_round_last, acc_dummy;
    logic [4:0]            acc_shift;

    logic [SP_ENTRY_W-1:0] sp_mem [0:3];
    int                    stub_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model bookkeeping
    bit          pending, in_round;
    int          cur_round, n_issue, low_run;
    logic [WW-1:0] exp_word;
    bit          exp_oa;
    int          n_clear, n_rstart, n_rlast, n_done, n_valid;

    always #5 clk = ~clk;

    round_scheduler #(
        .WORD_WIDTH(WW), .NORMAL_WORD_COUNT(NWC), .QUEUE_SIZE(QS),
        .WEIGHT(WT), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .sp_addr(sp_addr), .sp_rdata(sp_rdata), .nw_addr(nw_addr), .nw_rdata(nw_rdata),
        .rb_rst_n(rb_rst_n), .rb_word(rb_word), .rb_word_valid(rb_word_valid),
        .rb_only_add(rb_only_add), .rb_sparse_diff(rb_sparse_diff),
        .rb_high_latency(rb_high_latency), .rb_low_latency(rb_low_latency),
        .rb_processing_done(rb_processing_done), .acc_round_start(acc_round_start),
        .acc_round_last(acc_round_last), .acc_shift(acc_shift), .acc_dummy(acc_dummy)
    );

    // Sparse and normal memories with one-cycle read latency; normal word k = k+1,
    // out-of-range reads return a marker that must never reach round_block.
    always @(posedge clk) begin
        sp_rdata <= sp_mem[sp_addr];
        nw_rdata <= (nw_addr < AW'(NWC)) ? (32'(nw_addr) + 32'd1) : 32'hDEAD_BEEF;
    end

    // round_block stand-in: fixed latency per issue, plus stray completion
    // pulses while it is held in clear, which the scheduler must ignore.
    always @(posedge clk) begin
        if (rst) begin
            stub_cnt           <= 0;
            rb_processing_done <= 1'b0;
        end else begin
            rb_processing_done <= ~rb_rst_n;
            if (stub_cnt == 1) begin
                rb_processing_done <= 1'b1;
                stub_cnt           <= 0;
            end else if (stub_cnt > 1) begin
                stub_cnt <= stub_cnt - 1;
            end
            if (rb_word_valid) stub_cnt <= STUB_LAT;
        end
    end

    function automatic logic [SP_ENTRY_W-1:0] mk(input bit dm, input bit hi, input bit lo,
                                                 input int diff, input int sh);
        return {dm, hi, lo, 6'(diff), 5'(sh)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the round/issue model.
    task automatic monitor();
        logic [SP_ENTRY_W-1:0] ent;
        int diff;
        if (rst) begin
            pending  = 0;
            in_round = 0;
            low_run  = 0;
            return;
        end
        if (!rb_rst_n) begin
            low_run++;
        end else if (low_run != 0) begin
            check("clear_len", 32'(low_run), 32'd2);
            low_run = 0;
            n_clear++;
        end
        if (acc_round_start) begin
            check("clear_at_round_start", 32'(rb_rst_n), 32'd0);
            in_round = 1;
            n_issue  = 0;
            n_rstart++;
        end
        ent  = sp_mem[cur_round & 3];
        diff = int'(ent[10:5]);
        if (in_round) begin
            check("rb_sparse_diff", 32'(rb_sparse_diff), 32'(ent[10:5]));
            check("acc_shift",      32'(acc_shift),      32'(ent[4:0]));
            check("acc_dummy",      32'(acc_dummy),      32'(ent[13]));
            check("rb_high_lat",    32'(rb_high_latency), 32'(ent[12]));
            check("rb_low_lat",     32'(rb_low_latency),  32'(ent[11]));
        end
        if (rb_word_valid) begin
            check("valid_in_round", 32'(in_round), 32'd1);
            check("valid_not_pending", 32'(pending), 32'd0);
            exp_word = (n_issue < NWC) ? 32'(n_issue + 1) : 32'd0;
            exp_oa   = (n_issue == 0) || (n_issue > NWC + diff);
            check("rb_word", rb_word, exp_word);
            check("rb_only_add", 32'(rb_only_add), 32'(exp_oa));
            pending = 1;
            n_issue++;
            n_valid++;
        end else if (pending) begin
            check("rb_word_held", rb_word, exp_word);
            check("rb_only_add_held", 32'(rb_only_add), 32'(exp_oa));
            if (rb_processing_done) pending = 0;
        end
        if (acc_round_last) begin
            check("issues_per_round", 32'(n_issue), 32'(ISSUES));
            check("round_last_not_pending", 32'(pending), 32'd0);
            in_round = 0;
            cur_round++;
            n_rlast++;
        end
        if (done) n_done++;
        if (error) check("nw_addr_after_error", 32'(nw_addr), 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},        32'(busy), 32'd0);
        check({tag, "_done"},        32'(done), 32'd0);
        check({tag, "_rb_rst_n"},    32'(rb_rst_n), 32'd1);
        check({tag, "_valid"},       32'(rb_word_valid), 32'd0);
        check({tag, "_word"},        rb_word, 32'd0);
        check({tag, "_only_add"},    32'(rb_only_add), 32'd0);
        check({tag, "_diff"},        32'(rb_sparse_diff), 32'd0);
        check({tag, "_hi_lo"},       32'({rb_high_latency, rb_low_latency}), 32'd0);
        check({tag, "_acc_shift"},   32'(acc_shift), 32'd0);
        check({tag, "_acc_dummy"},   32'(acc_dummy), 32'd0);
        check({tag, "_acc_pulses"},  32'({acc_round_start, acc_round_last}), 32'd0);
        check({tag, "_addrs"},       32'({sp_addr, nw_addr}), 32'd0);
    endtask

    task automatic set_table(input logic [SP_ENTRY_W-1:0] e0, input logic [SP_ENTRY_W-1:0] e1,
                             input logic [SP_ENTRY_W-1:0] e2);
        sp_mem[0] = e0;
        sp_mem[1] = e1;
        sp_mem[2] = e2;
        sp_mem[3] = '0;
    endtask

    // Pulses start, then follows the run until done, error or the cycle budget.
    task automatic run(input int start_again_at, output int cyc, output bit got_done,
                       output bit got_err);
        bit finished;
        cur_round = 0;
        cyc       = 0;
        got_done  = 0;
        got_err   = 0;
        finished  = 0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("error_cleared_by_start", 32'(error), 32'd0);
        for (int i = 0; i < 20000; i++) begin
            if (busy) cyc++;
            if (done) begin
                got_done = 1;
                finished = 1;
                break;
            end
            if (!busy) begin
                got_err  = error;
                finished = 1;
                break;
            end
            start = (i == start_again_at);
            tick();
        end
        start = 1'b0;
        check("run_terminates", 32'(finished), 32'd1);
    endtask

    initial begin
        int  cyc_a, cyc_b, cyc_c;
        bit  dn, er;
        int  b_clear, b_rstart, b_rlast, b_done, b_valid;

        pending = 0; in_round = 0; cur_round = 0; n_issue = 0; low_run = 0;
        n_clear = 0; n_rstart = 0; n_rlast = 0; n_done = 0; n_valid = 0;
        exp_word = '0; exp_oa = 0;
        set_table('0, '0, '0);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("rb_rst_n_during_rst", 32'(rb_rst_n), 32'd0);
        rst = 1'b0;
        tick();
        check_idle("reset");
        check("reset_error", 32'(error), 32'd0);

        // Run A: every entry real, diff 0, shift 3
        set_table(mk(0, 0, 0, 0, 3), mk(0, 0, 0, 0, 3), mk(0, 0, 0, 0, 3));
        b_clear = n_clear; b_rstart = n_rstart; b_rlast = n_rlast; b_done = n_done; b_valid = n_valid;
        run(-1, cyc_a, dn, er);
        check("A_done", 32'(dn), 32'd1);
        check("A_cycles", 32'(cyc_a), 32'(EXP_CYC));
        check("A_clears", 32'(n_clear - b_clear), 32'(WT));
        check("A_round_starts", 32'(n_rstart - b_rstart), 32'(WT));
        check("A_round_lasts", 32'(n_rlast - b_rlast), 32'(WT));
        check("A_done_pulses", 32'(n_done - b_done), 32'd1);
        check("A_valids", 32'(n_valid - b_valid), 32'(WT * ISSUES));
        check("A_error", 32'(error), 32'd0);
        tick();
        check("A_busy_falls", 32'(busy), 32'd0);
        check("A_done_one_cycle", 32'(done), 32'd0);

        // Run B: all dummy, diff 16, with a start pulse while busy
        set_table(mk(1, 1, 0, 16, 0), mk(1, 0, 1, 16, 17), mk(1, 1, 1, 16, 31));
        b_done = n_done; b_rlast = n_rlast; b_valid = n_valid;
        run(100, cyc_b, dn, er);
        check("B_done", 32'(dn), 32'd1);
        check("B_const_time", 32'(cyc_b), 32'(cyc_a));
        check("B_round_lasts", 32'(n_rlast - b_rlast), 32'(WT));
        check("B_valids", 32'(n_valid - b_valid), 32'(WT * ISSUES));
        repeat (5) tick();
        check("B_done_pulses", 32'(n_done - b_done), 32'd1);
        check_idle("after_B");

        // Run C: offset out of range at round 2
        set_table(mk(0, 1, 0, 5, 7), mk(1, 0, 1, 9, 31), mk(0, 0, 0, 17, 2));
        b_done = n_done; b_rlast = n_rlast; b_clear = n_clear;
        run(-1, cyc_c, dn, er);
        check("C_no_done", 32'(dn), 32'd0);
        check("C_error", 32'(er), 32'd1);
        check("C_busy", 32'(busy), 32'd0);
        check("C_round_lasts", 32'(n_rlast - b_rlast), 32'd2);
        repeat (20) tick();
        check("C_clears", 32'(n_clear - b_clear), 32'd2);
        check("C_done_pulses", 32'(n_done - b_done), 32'd0);
        check("C_error_sticky", 32'(error), 32'd1);
        check_idle("after_C");

        // Run D: reset in the middle of a run
        set_table(mk(0, 0, 0, 3, 9), mk(0, 0, 0, 3, 9), mk(0, 0, 0, 3, 9));
        b_done = n_done;
        cur_round = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("D_error_cleared", 32'(error), 32'd0);
        check("D_busy", 32'(busy), 32'd1);
        repeat (1000) tick();
        rst = 1'b1;
        #1;
        check("D_rb_rst_n_comb", 32'(rb_rst_n), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset_error", 32'(error), 32'd0);
        repeat (50) tick();
        check("D_no_done", 32'(n_done - b_done), 32'd0);
        check("D_idle_busy", 32'(busy), 32'd0);

        // start and rst together: reset wins
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("start_with_rst_busy", 32'(busy), 32'd0);
        check("start_with_rst_sp_addr", 32'(sp_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
